// File: rtl/riscv_mem_pkg.sv
// Shared data-memory definitions: funct3 width codes,
// LSU state encoding and access classification helpers.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_SPLIT,
        S_RESP
    } lsu_state_t;

    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        unique case (1'b1)
            (f3 == F3_H),
            (f3 == F3_HU): m = lo[0];
            (f3 == F3_W):  m = (lo != 2'b00);
            default:       m = 1'b0;
        endcase
        return m;
    endfunction

    // Unsigned widths have no store form.
    function automatic logic is_illegal(
        input logic [2:0] f3,
        input logic       we
    );
        return (f3 == 3'd3) || (f3[2:1] == 2'b11) ||
               (we && (f3 == F3_BU || f3 == F3_HU));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the
// load/store unit, seen from the unit (slave) or its peers.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_func3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_misaligned;
    logic                  rsp_err;

    logic                  mem_we;
    logic [2:0]            mem_func3;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_func3,
        input  req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata,
        output rsp_misaligned, rsp_err,
        input  rsp_ready,
        output mem_we, mem_func3,
        output mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_func3,
        output req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        input  rsp_misaligned, rsp_err,
        output rsp_ready,
        input  mem_we, mem_func3,
        input  mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an LSB-aligned load word
// according to its funct3 width code.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    always_comb begin
        result = 32'd0;
        unique case (1'b1)
            (func3 == F3_B):
                result = {{24{word[7]}}, word[7:0]};
            (func3 == F3_H):
                result = {{16{word[15]}}, word[15:0]};
            (func3 == F3_W):
                result = word;
            (func3 == F3_BU):
                result = {24'd0, word[7:0]};
            (func3 == F3_HU):
                result = {16'd0, word[15:0]};
            default:
                result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: aligned accesses go out in one
// cycle, misaligned ones are split into byte accesses.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    lsu_state_t            state_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            cnt_q;
    logic [1:0]            last_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next;
    logic [DATA_WIDTH-1:0] ext;
    logic [1:0]            nxt;

    assign nxt = cnt_q + 2'd1;

    // Assembly including the byte being read this cycle.
    always_comb begin
        asm_next = asm_q;
        asm_next[int'(cnt_q)*BYTE_WIDTH +: BYTE_WIDTH] =
            bus.mem_rdata[BYTE_WIDTH-1:0];
    end

    load_extend u_ext (
        .word   (asm_next),
        .func3  (f3_q),
        .result (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            we_q               <= 1'b0;
            f3_q               <= F3_W;
            wdata_q            <= '0;
            cnt_q              <= 2'd0;
            last_q             <= 2'd0;
            asm_q              <= '0;
            bus.req_ready      <= 1'b1;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_rdata      <= '0;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_err        <= 1'b0;
            bus.mem_we         <= 1'b0;
            bus.mem_func3      <= F3_W;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    we_q          <= bus.req_we;
                    f3_q          <= bus.req_func3;
                    wdata_q       <= bus.req_wdata;
                    bus.req_ready <= 1'b0;
                    if (is_illegal(bus.req_func3, bus.req_we)) begin
                        state_q            <= S_RESP;
                        bus.rsp_valid      <= 1'b1;
                        bus.rsp_err        <= 1'b1;
                        bus.rsp_misaligned <= 1'b0;
                        bus.rsp_rdata      <= '0;
                    end else if (is_misaligned(bus.req_func3,
                                               bus.req_addr[1:0])) begin
                        state_q       <= S_SPLIT;
                        cnt_q         <= 2'd0;
                        last_q        <= (bus.req_func3 == F3_W) ?
                                         2'd3 : 2'd1;
                        asm_q         <= '0;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_func3 <= bus.req_we ? F3_B : F3_BU;
                        bus.mem_we    <= bus.req_we;
                        bus.mem_wdata <= DATA_WIDTH'(
                            bus.req_wdata[BYTE_WIDTH-1:0]);
                    end else begin
                        state_q       <= S_ACCESS;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_func3 <= bus.req_func3;
                        bus.mem_we    <= bus.req_we;
                        bus.mem_wdata <= bus.req_wdata;
                    end
                end
                S_ACCESS: begin
                    state_q            <= S_RESP;
                    bus.mem_we         <= 1'b0;
                    bus.rsp_valid      <= 1'b1;
                    bus.rsp_err        <= 1'b0;
                    bus.rsp_misaligned <= 1'b0;
                    bus.rsp_rdata      <= we_q ? '0 : bus.mem_rdata;
                end
                S_SPLIT: begin
                    if (!we_q)
                        asm_q <= asm_next;
                    if (cnt_q == last_q) begin
                        state_q            <= S_RESP;
                        bus.mem_we         <= 1'b0;
                        bus.rsp_valid      <= 1'b1;
                        bus.rsp_err        <= 1'b0;
                        bus.rsp_misaligned <= 1'b1;
                        bus.rsp_rdata      <= we_q ? '0 : ext;
                    end else begin
                        cnt_q         <= nxt;
                        bus.mem_addr  <= bus.mem_addr + ADDR_WIDTH'(1);
                        bus.mem_wdata <= DATA_WIDTH'(
                            wdata_q[int'(nxt)*BYTE_WIDTH +: BYTE_WIDTH]);
                    end
                end
                S_RESP: if (bus.rsp_ready) begin
                    state_q       <= S_IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the execute/memory stage over a valid/ready handshake and drives the byte-addressed data memory (sync write, comb read, func3-coded width).
- Aligned accesses are issued as one memory access. Misaligned halfword/word accesses are split into sequential byte accesses. Load bytes are reassembled, sign- or zero-extended, and returned on a registered response channel.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width (fixed 4 byte lanes)
BYTE_WIDTH, 8, bits per byte

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_func3  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, LSB-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA_WIDTH  extended load result; 0 for stores
rsp_misaligned  out  1  request was split
rsp_err  out  1  illegal func3; no memory access made
mem_we  out  1  memory write enable
mem_func3  out  3  memory width code
mem_addr  out  ADDR_WIDTH  memory byte address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory combinational read data

Behaviour:
- Reset (async, rst=1): state IDLE. req_ready=1. rsp_valid=0, rsp_rdata=0, rsp_misaligned=0, rsp_err=0. mem_we=0, mem_func3=2, mem_addr=0, mem_wdata=0. Byte counter and assembly register are 0.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. If req_valid, capture we/func3/addr/wdata.
  - func3 in {3,6,7}: go to RESP with rsp_err=1 and rdata=0.
  - Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): go to SPLIT with byte counter 0 and nbytes = 2 (H) or 4 (W).
  - Otherwise go to ACCESS.
- Stores with func3 4 or 5 are illegal (rsp_err=1).
- ACCESS, one cycle: mem_addr=captured addr, mem_func3=captured func3, mem_we=captured we, mem_wdata=captured wdata. For loads, register mem_rdata as rsp_rdata. The memory performs extension for aligned accesses. Go to RESP.
- SPLIT, one cycle per byte k = 0..nbytes-1: mem_addr=addr+k (wraps modulo 2^ADDR_WIDTH).
  - Store: mem_func3=0, mem_wdata[7:0]=wdata byte k, mem_we=1.
  - Load: mem_func3=4 (LBU), mem_we=0, and mem_rdata[7:0] is written into assembly byte k.
  - After byte nbytes-1: extend the assembly (sign for 1/2, zero for 4/5, none for W) into rsp_rdata, set rsp_misaligned=1, go to RESP.
- RESP: rsp_valid=1 and outputs held stable until rsp_ready. On rsp_ready, go to IDLE and clear rsp_valid the next cycle.
- mem_we is 1 only in ACCESS/SPLIT store cycles, never in IDLE/RESP.
- req_ready=0 outside IDLE. No request overlap, so at most one outstanding request.
- Latency from accept to rsp_valid: aligned 2 cycles; misaligned nbytes+1 cycles; illegal 1 cycle.
- rst asserted mid-split: abandon immediately with no further mem_we. Bytes already written stay written.
- rsp_ready held high in RESP: one response per request. The back-to-back request minimum period is latency+1.

Decomposition:
- Shared package riscv_mem_pkg: func3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5), lsu_state_t enum, helper function is_misaligned(func3, addr[1:0]).
- One sub-module is natural: load_extend (combinational; assembly word + func3 -> extended 32-bit result), reused by ACCESS-bypass checks in the bench.

Test Plan:
- Aligned SW 0xDEADBEEF @0x10000 then LW @0x10000 -> exactly one mem_we cycle, func3=2; rsp_rdata=0xDEADBEEF, rsp_misaligned=0, each response 2 cycles after accept.
- Memory bytes 0x10001=0x80, 0x10002=0xFF; LH @0x10001 -> two LBU cycles at 0x10001 and 0x10002; rsp_rdata=0xFFFFFF80... more precisely {0xFF,0x80} sign-extended = 0xFFFFFF80; LHU same address -> 0x0000FF80; rsp_misaligned=1; latency 3.
- SW 0x11223344 @0x10003 -> four byte writes: 0x10003=0x44, 0x10004=0x33, 0x10005=0x22, 0x10006=0x11. A following LW @0x10003 returns 0x11223344 with latency 5.
- Load func3=3 @0x10000 -> no mem_we and no split; rsp_err=1, rsp_rdata=0, latency 1. Store func3=4 -> rsp_err=1, memory unchanged.
- Hold rsp_ready=0 for 5 cycles after an LB of byte 0x9C -> rsp_valid and rsp_rdata=0xFFFFFF9C stable, req_ready=0, mem_we=0 throughout.
- Assert rst during the second byte of a misaligned SW -> all outputs at reset values asynchronously; only byte 0 modified; the next aligned request completes normally.
